// File: rtl/keypad_operand_multiplier.sv
// Multiplies two signed 2-digit BCD keypad operands with a sequential shift-add engine.
// Defining MULT_BCD_OUT_EN adds a double-dabble stage that drives product_bcd.
module keypad_operand_multiplier #(
   parameter int unsigned ITER   = 7,
   parameter int unsigned PROD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        a_bcd,
   input  logic [7:0]        b_bcd,
   input  logic              a_neg,
   input  logic              b_neg,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PROD_W-1:0] product,
   output logic [15:0]       product_bcd
);

   localparam int unsigned MAG_W = 2 * ITER;

`ifdef MULT_BCD_OUT_EN
   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_MULT, S_SIGN, S_BCD} state_t;
   localparam int unsigned DD_W = 16 + MAG_W;
   logic [DD_W-1:0] dd_q, dd_d, dd_adj;
   logic [15:0]     bcd_q, bcd_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_MULT, S_SIGN} state_t;
`endif

   state_t            state_q, state_d;
   logic [7:0]        a_q, a_d, b_q, b_d;
   logic              sign_q, sign_d;
   logic [MAG_W-1:0]  mcand_q, mcand_d, acc_q, acc_d;
   logic [ITER-1:0]   mplier_q, mplier_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [PROD_W-1:0] prod_q, prod_d, mag_ext;
   logic [ITER-1:0]   a_bin, b_bin;
   logic              bad_nibble;

   assign bad_nibble = (a_q[3:0] > 4'd9) || (a_q[7:4] > 4'd9) ||
                       (b_q[3:0] > 4'd9) || (b_q[7:4] > 4'd9);
   // Low nibble is the tens digit (first key pressed).
   assign a_bin   = ITER'(a_q[3:0]) * ITER'(10) + ITER'(a_q[7:4]);
   assign b_bin   = ITER'(b_q[3:0]) * ITER'(10) + ITER'(b_q[7:4]);
   assign mag_ext = PROD_W'(acc_q);

`ifdef MULT_BCD_OUT_EN
   always_comb begin
      dd_adj = dd_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (dd_adj[MAG_W+4*i +: 4] >= 4'd5)
            dd_adj[MAG_W+4*i +: 4] = dd_adj[MAG_W+4*i +: 4] + 4'd3;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      prod_d   = prod_q;
`ifdef MULT_BCD_OUT_EN
      dd_d     = dd_q;
      bcd_d    = bcd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_bcd;
               b_d     = b_bcd;
               sign_d  = a_neg ^ b_neg;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            if (bad_nibble) begin
               err_d   = 1'b1;
               prod_d  = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
`ifdef MULT_BCD_OUT_EN
               bcd_d   = '0;
`endif
               state_d = S_IDLE;
            end else begin
               mcand_d  = MAG_W'(a_bin);
               mplier_d = b_bin;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_MULT;
            end
         end
         S_MULT: begin
            if (mplier_q[0])
               acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'(ITER - 1))
               state_d = S_SIGN;
         end
         S_SIGN: begin
            // Negating a zero magnitude is still zero, so no special case is needed.
            prod_d = sign_q ? -mag_ext : mag_ext;
`ifdef MULT_BCD_OUT_EN
            dd_d    = DD_W'(acc_q);
            cnt_d   = '0;
            state_d = S_BCD;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
         end
`ifdef MULT_BCD_OUT_EN
         S_BCD: begin
            dd_d  = dd_adj << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(MAG_W - 1)) begin
               bcd_d   = dd_d[DD_W-1 -: 16];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         prod_q   <= '0;
`ifdef MULT_BCD_OUT_EN
         dd_q     <= '0;
         bcd_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         prod_q   <= prod_d;
`ifdef MULT_BCD_OUT_EN
         dd_q     <= dd_d;
         bcd_q    <= bcd_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign product = prod_q;
`ifdef MULT_BCD_OUT_EN
   assign product_bcd = bcd_q;
`else
   assign product_bcd = '0;
`endif

endmodule

// File: tb/tb_keypad_operand_multiplier.sv
// Randomized and directed bench for keypad_operand_multiplier against an arithmetic reference model.
module tb_keypad_operand_multiplier;

`ifdef MULT_BCD_OUT_EN
   localparam bit BCD_EN = 1'b1;
`else
   localparam bit BCD_EN = 1'b0;
`endif
   localparam int LAT = BCD_EN ? 23 : 9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a_bcd = '0, b_bcd = '0;
   logic        a_neg = 1'b0, b_neg = 1'b0;
   logic        busy, done, err;
   logic [15:0] product, product_bcd;

   int total = 0;
   int bad   = 0;

   keypad_operand_multiplier #(.ITER(7), .PROD_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_bcd(a_bcd), .b_bcd(b_bcd), .a_neg(a_neg), .b_neg(b_neg),
      .busy(busy), .done(done), .err(err),
      .product(product), .product_bcd(product_bcd)
   );

   always #5 clk = ~clk;

   // Reference: decimal value of the digits, integer product, sign applied, decimal digits of |product|.
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic an,
                                 input logic bn, output logic [15:0] p, output logic e,
                                 output logic [15:0] bcd, output int lat);
      int ta, ua, tb, ub, m, s;
      ta = int'(a[3:0]); ua = int'(a[7:4]);
      tb = int'(b[3:0]); ub = int'(b[7:4]);
      if (ta > 9 || ua > 9 || tb > 9 || ub > 9) begin
         p = 16'h0; e = 1'b1; bcd = 16'h0; lat = 1;
         return;
      end
      m = (ta * 10 + ua) * (tb * 10 + ub);
      s = (an != bn) ? -m : m;
      p = 16'(s);
      e = 1'b0;
      bcd = BCD_EN ? {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)} : 16'h0;
      lat = LAT;
   endfunction

   function automatic logic [3:0] rnib();
      if ($urandom_range(0, 15) == 0) return 4'($urandom_range(10, 15));
      return 4'($urandom_range(0, 9));
   endfunction

   // Caller is positioned just after a rising edge; start is sampled on the next one.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic an, input logic bn);
      a_bcd = a; b_bcd = b; a_neg = an; b_neg = bn; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit seen);
      n = 0; seen = 1'b0;
      while (n < 60 && !seen) begin
         @(posedge clk); #1;
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if ({busy, done, err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, err});
      end
      total++;
      if (product !== 16'h0000 || product_bcd !== 16'h0000) begin
         bad++; $display("FAIL reset_data got=%h/%h want=0000/0000", product, product_bcd);
      end
   endtask

   task automatic test_directed();
      logic [7:0]  ta[5], tb[5];
      logic        tan[5], tbn[5], te[5];
      logic [15:0] tp[5], tbcd[5];
      int n, lat; bit seen;
      ta = '{8'h21, 8'h99, 8'h99, 8'h00, 8'h1A};
      tb = '{8'h43, 8'h99, 8'h99, 8'h70, 8'h70};
      tan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbn = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tp = '{16'h0198, 16'hD9B7, 16'h2649, 16'h0000, 16'h0000};
      te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbcd = '{16'h0408, 16'h9801, 16'h9801, 16'h0000, 16'h0000};
      for (int i = 0; i < 5; i++) begin
         lat = te[i] ? 1 : LAT;
         launch(ta[i], tb[i], tan[i], tbn[i]);
         total++;
         if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b want=1", i, busy); end
         wait_done(n, seen);
         total++;
         if (!seen || n != lat) begin
            bad++; $display("FAIL dir%0d_latency got=%0d seen=%0b want=%0d", i, n, seen, lat);
         end
         total++;
         if (product !== tp[i] || err !== te[i] || busy !== 1'b0) begin
            bad++; $display("FAIL dir%0d_result got=%h err=%b busy=%b want=%h err=%b busy=0",
                            i, product, err, busy, tp[i], te[i]);
         end
         total++;
         if (product_bcd !== (BCD_EN ? tbcd[i] : 16'h0)) begin
            bad++; $display("FAIL dir%0d_bcd got=%h want=%h", i, product_bcd, BCD_EN ? tbcd[i] : 16'h0);
         end
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || product !== tp[i] || err !== te[i]) begin
            bad++; $display("FAIL dir%0d_hold done=%b product=%h err=%b want done=0 %h %b",
                            i, done, product, err, tp[i], te[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] a, b; logic an, bn, e;
      logic [15:0] p, bcd; int lat, n; bit seen;
      for (int i = 0; i < 30; i++) begin
         a = {rnib(), rnib()}; b = {rnib(), rnib()};
         an = 1'($urandom_range(0, 1)); bn = 1'($urandom_range(0, 1));
         model(a, b, an, bn, p, e, bcd, lat);
         launch(a, b, an, bn);
         a_bcd = 8'($urandom); b_bcd = 8'($urandom);
         a_neg = 1'($urandom_range(0, 1)); b_neg = 1'($urandom_range(0, 1));
         total++;
         if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rnd%0d_accept err=%b busy=%b want err=0 busy=1", i, err, busy);
         end
         wait_done(n, seen);
         total++;
         if (!seen || n != lat) begin
            bad++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d want=%0d", i, a, b, n, lat);
         end
         total++;
         if (product !== p || err !== e || product_bcd !== bcd) begin
            bad++; $display("FAIL rnd%0d_result a=%h b=%h s=%b%b got=%h/%b/%h want=%h/%b/%h",
                            i, a, b, an, bn, product, err, product_bcd, p, e, bcd);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int n; bit seen;
      launch(8'h21, 8'h43, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      launch(8'h55, 8'h77, 1'b1, 1'b0);
      wait_done(n, seen);
      total++;
      if (!seen || n + 3 != LAT) begin
         bad++; $display("FAIL b2b_ignored_latency got=%0d want=%0d", n + 3, LAT);
      end
      total++;
      if (product !== 16'h0198 || err !== 1'b0) begin
         bad++; $display("FAIL b2b_ignored_result got=%h err=%b want=0198 err=0", product, err);
      end
      launch(8'h99, 8'h99, 1'b1, 1'b1);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_done_cycle_accept busy=%b want=1", busy); end
      wait_done(n, seen);
      total++;
      if (!seen || n != LAT || product !== 16'h2649) begin
         bad++; $display("FAIL b2b_second got=%h lat=%0d want=2649 lat=%0d", product, n, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int n; bit seen;
      launch(8'h21, 8'h43, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, err} !== 3'b000 || product !== 16'h0 || product_bcd !== 16'h0) begin
         bad++; $display("FAIL rstmid_outputs got=%b %h %h want=000 0000 0000",
                         {busy, done, err}, product, product_bcd);
      end
      @(posedge clk); #1 rst = 1'b0;
      wait_done(n, seen);
      total++;
      if (seen) begin bad++; $display("FAIL rstmid_no_done got done after %0d want none", n); end
      launch(8'h43, 8'h21, 1'b0, 1'b1);
      wait_done(n, seen);
      total++;
      if (!seen || n != LAT || product !== 16'hFE68 || product_bcd !== (BCD_EN ? 16'h0408 : 16'h0)) begin
         bad++; $display("FAIL rstmid_recover got=%h/%h lat=%0d want=fe68 lat=%0d", product, product_bcd, n, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
